// File: rtl/lpf_stream_ctrl_pkg.sv
// lpf_stream_ctrl_pkg: shared widths and FSM encoding for the LPF stream controller and its filter
package lpf_stream_ctrl_pkg;
  localparam int N_DEF = 16;
  localparam int M_DEF = 13;
  localparam int DEPTH_DEF = 102;
  localparam int AW_DEF = 8;
  typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/lpf_stream_ctrl_if.sv
// lpf_stream_ctrl_if: control, sample-memory and filter signals of the LPF stream controller
interface lpf_stream_ctrl_if import lpf_stream_ctrl_pkg::*; #(
  parameter int N = N_DEF,
  parameter int AW = AW_DEF
);
  logic start, abort, loop_en;
  logic [AW-1:0] num_samples;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [N-1:0] mem_rdata;
  logic fir_en;
  logic [N-1:0] fir_data_in;
  logic fir_valid;
  logic [N-1:0] fir_data_out;
  logic out_valid;
  logic [N-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic busy, done, err;
  modport master (
    input start, abort, loop_en, num_samples, mem_rdata, fir_valid, fir_data_out,
    output mem_rd, mem_addr, fir_en, fir_data_in, out_valid, out_data, out_idx, busy, done, err
  );
  modport slave (
    output start, abort, loop_en, num_samples, mem_rdata, fir_valid, fir_data_out,
    input mem_rd, mem_addr, fir_en, fir_data_in, out_valid, out_data, out_idx, busy, done, err
  );
endinterface

// File: rtl/lpf_addr_gen.sv
// lpf_addr_gen: sample address counter with clamped pass length, terminal count and wrap
module lpf_addr_gen #(
  parameter int AW = 8,
  parameter int DEPTH = 102
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [AW-1:0] num_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] num_o,
  output logic          tc_o
);
  logic [AW-1:0] addr_q, addr_d, num_q, num_d;
  assign tc_o = addr_q == num_q - AW'(1);
  always_comb begin
    num_d = load_i ? ((int'(num_i) > DEPTH) ? AW'(DEPTH) : num_i) : num_q;
    addr_d = clr_i ? '0 : adv_i ? (tc_o ? '0 : addr_q + AW'(1)) : addr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      addr_q <= '0;
      num_q <= '0;
    end else begin
      addr_q <= addr_d;
      num_q <= num_d;
    end
  assign addr_o = addr_q;
  assign num_o = num_q;
endmodule

// File: rtl/lpf_stream_ctrl.sv
// lpf_stream_ctrl: plays samples from memory through an FIR filter, flushing first and capturing outputs
module lpf_stream_ctrl import lpf_stream_ctrl_pkg::*; #(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk_i,
  input logic rst_ni,
  lpf_stream_ctrl_if.master io
);
  localparam int CW = $clog2(4 * M);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] num, addr, ocnt_q, out_idx_q;
  logic [N-1:0] fir_data_q, out_data_q;
  logic tc, start_ok, zero_start, mem_rd, cap, tmo;
  logic stop_q, v1_q, v2_q, l1_q, l2_q, zdone_q, err_q, out_valid_q;
  assign start_ok = state_q == IDLE && io.start && !io.abort;
  assign zero_start = start_ok && io.num_samples == '0;
  assign mem_rd = state_q == STREAM && !stop_q;
  assign cap = io.fir_valid && (state_q == STREAM || state_q == DRAIN) && !io.abort;
  assign tmo = state_q == DRAIN && ocnt_q != num && cnt_q == CW'(4 * M - 1);
  lpf_addr_gen #(.AW(AW), .DEPTH(DEPTH)) u_addr_gen (
    .clk_i, .rst_ni,
    .load_i(start_ok), .num_i(io.num_samples),
    .clr_i(state_q != STREAM), .adv_i(mem_rd),
    .addr_o(addr), .num_o(num), .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_ok && !zero_start) state_d = FLUSH;
      end
      FLUSH: if (cnt_q == CW'(M - 1)) begin
        state_d = STREAM;
        cnt_d = '0;
      end
      STREAM: begin
        cnt_d = '0;
        if (l2_q) state_d = DRAIN;
      end
      DRAIN: if (ocnt_q == num || tmo) state_d = DONE;
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
    if (io.abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  // v*/l* carry "sample valid" and "final sample" alongside the 2-cycle memory+register pipe
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      {stop_q, v1_q, v2_q, l1_q, l2_q, zdone_q, err_q, out_valid_q} <= '0;
      ocnt_q <= '0;
      out_idx_q <= '0;
      fir_data_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stop_q <= mem_rd ? tc && !io.loop_en : stop_q && state_q == STREAM;
      v1_q <= mem_rd && !io.abort;
      l1_q <= mem_rd && tc && !io.loop_en && !io.abort;
      v2_q <= v1_q && !io.abort;
      l2_q <= l1_q && !io.abort;
      fir_data_q <= (v1_q && !io.abort) ? io.mem_rdata : '0;
      zdone_q <= zero_start;
      err_q <= start_ok ? zero_start : err_q || tmo;
      out_valid_q <= cap;
      if (cap) begin
        out_data_q <= io.fir_data_out;
        out_idx_q <= ocnt_q == num ? '0 : ocnt_q;
        ocnt_q <= ocnt_q == num ? AW'(1) : ocnt_q + AW'(1);
      end else if (state_q == IDLE) ocnt_q <= '0;
    end
  assign io.mem_rd = mem_rd;
  assign io.mem_addr = mem_rd ? addr : '0;
  assign io.fir_en = state_q == FLUSH || v2_q;
  assign io.fir_data_in = fir_data_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data = out_data_q;
  assign io.out_idx = out_idx_q;
  assign io.busy = state_q inside {FLUSH, STREAM, DRAIN};
  assign io.done = state_q == DONE || zdone_q;
  assign io.err = err_q;
endmodule

// File: tb/tb_lpf_stream_ctrl.sv
// tb_lpf_stream_ctrl: directed self-checking bench for lpf_stream_ctrl with memory and 2-tap filter models
module tb_lpf_stream_ctrl;
  import lpf_stream_ctrl_pkg::*;
  localparam int N = N_DEF;
  localparam int M = M_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AW = AW_DEF;
  logic clk = 0;
  logic rst_n = 1;
  logic fv_en = 1;
  logic mon_clr = 0;
  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] prev;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int addr_q[$], addr_c[$], fin_q[$], fin_c[$], oidx_q[$], odat_q[$];
  int done_cnt = 0, busy_seen = 0, drain_cnt = 0;
  int z, bad, p;
  lpf_stream_ctrl_if #(.N(N), .AW(AW)) io ();
  lpf_stream_ctrl #(.N(N), .M(M), .DEPTH(DEPTH), .AW(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (io.mem_rd) io.mem_rdata <= mem[io.mem_addr];
  assign io.fir_valid = io.fir_en && fv_en;
  assign io.fir_data_out = io.fir_data_in + prev;
  always @(posedge clk) if (io.fir_en) prev <= io.fir_data_in;
  always @(negedge clk)
    if (mon_clr) begin
      addr_q.delete(); addr_c.delete(); fin_q.delete(); fin_c.delete(); oidx_q.delete(); odat_q.delete();
      done_cnt = 0; busy_seen = 0; drain_cnt = 0;
    end else begin
      if (io.mem_rd) begin addr_q.push_back(int'(io.mem_addr)); addr_c.push_back(cyc); end
      if (io.fir_en) begin fin_q.push_back(int'(io.fir_data_in)); fin_c.push_back(cyc); end
      if (io.out_valid) begin oidx_q.push_back(int'(io.out_idx)); odat_q.push_back(int'(io.out_data)); end
      if (io.done) done_cnt++;
      if (io.busy) busy_seen++;
      if (io.busy && !io.mem_rd && !io.fir_en) drain_cnt++;
    end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic go(input int n, input logic lp);
    mon_clr = 1;
    @(negedge clk); #1 mon_clr = 0;
    @(posedge clk); #1;
    io.num_samples = AW'(n); io.loop_en = lp; io.start = 1;
    tick(1);
    io.start = 0;
  endtask
  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!io.done && k < lim) begin tick(1); k++; end
    chk({tag, "_done_seen"}, io.done, 1);
    tick(3);
  endtask
  task automatic wait_stream(input string tag);
    int k = 0;
    while (!io.mem_rd && k < 60) begin tick(1); k++; end
    chk({tag, "_stream_reached"}, io.mem_rd, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = N'(i + 1);
    io.start = 0; io.abort = 0; io.loop_en = 0; io.num_samples = '0;
    #2 rst_n = 0;
    #2;
    chk("rst_ctl", {io.mem_rd, io.fir_en, io.busy, io.done, io.err, io.out_valid}, 0);
    chk("rst_data", {io.mem_addr, io.fir_data_in, io.out_data, io.out_idx}, 0);
    @(posedge clk); #1 rst_n = 1;
    tick(2);
    chk("post_rst_idle", {io.busy, io.done, io.err}, 0);
    go(5, 0);
    wait_done("t1", 200);
    chk("t1_fir_en_cnt", fin_q.size(), M + 5);
    if (fin_q.size() == M + 5) begin
      z = 0;
      for (int i = 0; i < M; i++) if (fin_q[i] == 0) z++;
      chk("t1_flush_zeros", z, M);
      chk("t1_flush_span", fin_c[M-1] - fin_c[0], M - 1);
      for (int i = 0; i < 5; i++) chk("t1_sample", fin_q[M+i], i + 1);
      chk("t1_consec", fin_c[M+4] - fin_c[M], 4);
      if (addr_c.size() > 0) chk("t1_latency", fin_c[M] - addr_c[0], 2);
    end
    chk("t1_addr_cnt", addr_q.size(), 5);
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) bad++;
    chk("t1_addr_seq", bad, 0);
    chk("t1_out_cnt", oidx_q.size(), 5);
    bad = 0;
    foreach (oidx_q[i]) if (oidx_q[i] != i || odat_q[i] != 2 * i + 1) bad++;
    chk("t1_out_seq", bad, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", io.err, 0);
    go(0, 0);
    chk("t2_done", io.done, 1);
    chk("t2_err", io.err, 1);
    chk("t2_busy", io.busy, 0);
    tick(1);
    chk("t2_done_drop", io.done, 0);
    tick(3);
    chk("t2_busy_seen", busy_seen, 0);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_err_sticky", io.err, 1);
    go(200, 0);
    wait_done("t3", 400);
    chk("t3_addr_cnt", addr_q.size(), 102);
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) bad++;
    chk("t3_addr_seq", bad, 0);
    chk("t3_out_cnt", oidx_q.size(), 102);
    if (oidx_q.size() == 102) begin
      chk("t3_last_idx", oidx_q[101], 101);
      chk("t3_last_data", odat_q[101], 203);
    end
    chk("t3_err_cleared", io.err, 0);
    chk("t3_done_cnt", done_cnt, 1);
    go(4, 1);
    p = 0;
    for (int k = 0; k < 100 && p < 3; k++) begin
      if (io.mem_rd && io.mem_addr == 0) p++;
      if (p < 3) tick(1);
    end
    chk("t4_pass3", p, 3);
    io.loop_en = 0;
    wait_done("t4", 200);
    chk("t4_addr_cnt", addr_q.size(), 12);
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i % 4) bad++;
    chk("t4_addr_seq", bad, 0);
    chk("t4_out_cnt", oidx_q.size(), 12);
    bad = 0;
    foreach (oidx_q[i]) if (oidx_q[i] != i % 4) bad++;
    chk("t4_idx_wrap", bad, 0);
    bad = 0;
    foreach (odat_q[i]) if (odat_q[i] != (i % 4 + 1) + (i == 0 ? 0 : (i - 1) % 4 + 1)) bad++;
    chk("t4_data", bad, 0);
    chk("t4_done_cnt", done_cnt, 1);
    go(10, 0);
    wait_stream("t5");
    tick(3);
    chk("t5_fir_en_before", io.fir_en, 1);
    io.abort = 1; io.start = 1;
    tick(1);
    io.abort = 0; io.start = 0;
    chk("t5_abort_ctl", {io.mem_rd, io.fir_en, io.busy}, 0);
    tick(20);
    chk("t5_no_restart", io.busy, 0);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_addr_cnt", addr_q.size(), 4);
    fv_en = 0;
    go(3, 0);
    wait_done("t6", 200);
    chk("t6_drain_cycles", drain_cnt, 4 * M);
    chk("t6_err", io.err, 1);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_out_cnt", oidx_q.size(), 0);
    fv_en = 1;
    go(20, 0);
    wait_stream("t7");
    tick(5);
    chk("t7_busy_pre", io.busy, 1);
    rst_n = 0;
    #1;
    chk("t7_rst_ctl", {io.mem_rd, io.fir_en, io.busy, io.done, io.err, io.out_valid}, 0);
    chk("t7_rst_data", {io.mem_addr, io.fir_data_in, io.out_data, io.out_idx}, 0);
    @(posedge clk); #1 rst_n = 1;
    tick(3);
    chk("t7_post_rst", {io.mem_rd, io.fir_en, io.busy, io.done, io.err, io.out_valid}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
